sram_port_driver: RTL and testbench

// - Drives one external asynchronous SRAM chip (RAM1 or RAM2) for the RAM routing stage.
// - Sits directly downstream of that stage: it consumes need_to_work/mem_rd/mem_wr/addr/data
//   and returns work_done plus the read value (feedback).
// - One instance per chip. Multi-cycle strobe FSM with tri-state data bus control.

---
 rtl/sram_port_driver_if.sv | 53 +++++
 rtl/sram_port_driver.sv | 216 +++++++++++++++++++++
 tb/tb_sram_port_driver.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_driver_if.sv
// -----------------------------------------------------------------------------
// sram_port_driver_if
//
// Request/completion bundle between the RAM routing stage and one
// sram_port_driver instance. The member names are the original port names of
// the driver, so upstream code only changes where it connects.
//
// Members
//   need_to_work  routing stage -> driver   access request level
//   mem_rd        routing stage -> driver   read qualifier
//   mem_wr        routing stage -> driver   write qualifier (wins over mem_rd)
//   addr[15:0]    routing stage -> driver   word address
//   data_in       routing stage -> driver   write data
//   work_done     driver -> routing stage   one-cycle completion pulse
//   feedback      driver -> routing stage   last read (or written) value
//
// Modports
//   master : routing stage side
//   slave  : sram_port_driver side
// -----------------------------------------------------------------------------
interface sram_port_driver_if #(
    parameter int DATA_W = 16
);

    logic              need_to_work;
    logic              mem_rd;
    logic              mem_wr;
    logic [15:0]       addr;
    logic [DATA_W-1:0] data_in;
    logic              work_done;
    logic [DATA_W-1:0] feedback;

    modport master (
        output need_to_work,
        output mem_rd,
        output mem_wr,
        output addr,
        output data_in,
        input  work_done,
        input  feedback
    );

    modport slave (
        input  need_to_work,
        input  mem_rd,
        input  mem_wr,
        input  addr,
        input  data_in,
        output work_done,
        output feedback
    );

endinterface

// File: rtl/sram_port_driver.sv
// -----------------------------------------------------------------------------
// sram_port_driver
//
// Drives one external asynchronous SRAM chip on behalf of the RAM routing
// stage. An accepted request runs a fixed strobe sequence
//   IDLE -> SETUP -> STROBE (WAIT_CYCLES+1) -> DONE -> IDLE
// and returns a registered one-cycle work_done pulse plus the read value on
// feedback. Request inputs are latched at accept, so the upstream stage may
// change them freely while an access is in flight.
//
// Optional feature (compile-time macro SRAM_WRITE_READBACK_EN):
//   writes run SETUP -> STROBE(we) -> TURN -> RSTROBE(oe) -> DONE, and the value
//   read back from the chip is returned on feedback. Without the macro a
//   write returns its own latched data on feedback.
//
// Parameters
//   ADDR_W       external SRAM address width (>= 16); addr is zero-extended
//   DATA_W       data width
//   WAIT_CYCLES  extra strobe cycles; each strobe lasts WAIT_CYCLES+1 clocks
//
// Ports
//   clk          system clock, all state changes on posedge
//   rst          synchronous active-high reset; aborts an access in flight
//   up           request/completion bundle (slave side)
//   ram_addr     SRAM address, latched at accept
//   ram_data     SRAM data bus, driven only during write phases
//   ram_en       chip enable, active low
//   ram_oe       output enable, active low
//   ram_we       write enable, active low
// -----------------------------------------------------------------------------
module sram_port_driver #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    sram_port_driver_if.slave   up,
    output logic [ADDR_W-1:0]   ram_addr,
    inout  wire  [DATA_W-1:0]   ram_data,
    output logic                ram_en,
    output logic                ram_oe,
    output logic                ram_we
);

    // FSM encoding
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] STROBE  = 3'd2;
    localparam logic [2:0] DONE    = 3'd3;
`ifdef SRAM_WRITE_READBACK_EN
    localparam logic [2:0] TURN    = 3'd4;
    localparam logic [2:0] RSTROBE = 3'd5;
`endif

    localparam int               CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

    // State and latched request
    logic [2:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              wr_q,     wr_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] fb_q,     fb_d;

    // Registered pin / handshake outputs
    logic              done_q,   done_d;
    logic              en_q,     en_d;
    logic              oe_q,     oe_d;
    logic              we_q,     we_d;
    logic              drv_q,    drv_d;

    logic              strobe_last;
    logic              accept;

    assign strobe_last = (cnt_q == WAIT_LAST);
    assign accept      = up.need_to_work && (up.mem_rd || up.mem_wr);

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fb_d    = fb_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    wr_d    = up.mem_wr;
                    addr_d  = ADDR_W'(up.addr);
                    wdata_d = up.data_in;
                end
            end

            SETUP: begin
                state_d = STROBE;
                cnt_d   = '0;
            end

            STROBE: begin
                if (strobe_last) begin
                    cnt_d = '0;
                    if (!wr_q) begin
                        // Read data is sampled on the last strobe edge while oe is still low.
                        fb_d    = ram_data;
                        state_d = DONE;
                    end else begin
`ifdef SRAM_WRITE_READBACK_EN
                        state_d = TURN;
`else
                        fb_d    = wdata_q;
                        state_d = DONE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef SRAM_WRITE_READBACK_EN
            TURN: begin
                state_d = RSTROBE;
                cnt_d   = '0;
            end

            RSTROBE: begin
                if (strobe_last) begin
                    cnt_d   = '0;
                    fb_d    = ram_data;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pin levels are decoded from the next state and registered, so every
    // strobe edge is glitch-free and lines up with the state it belongs to.
    // wr_d is the latched op whenever state_d is not IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        done_d = (state_d == DONE);
        en_d   = (state_d == IDLE);
        we_d   = !((state_d == STROBE) && wr_d);
`ifdef SRAM_WRITE_READBACK_EN
        oe_d   = !(((state_d == STROBE) && !wr_d) || (state_d == RSTROBE));
        // The bus is released at TURN so the chip can drive it during the read-back strobe.
        drv_d  = wr_d && ((state_d == SETUP) || (state_d == STROBE));
`else
        oe_d   = !((state_d == STROBE) && !wr_d);
        // Write data is held through DONE to cover the chip's data hold time after we rises.
        drv_d  = wr_d && ((state_d == SETUP) || (state_d == STROBE) || (state_d == DONE));
`endif
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fb_q    <= '0;
            done_q  <= 1'b0;
            en_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            drv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fb_q    <= fb_d;
            done_q  <= done_d;
            en_q    <= en_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            drv_q   <= drv_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign up.work_done = done_q;
    assign up.feedback  = fb_q;
    assign ram_addr     = addr_q;
    assign ram_en       = en_q;
    assign ram_oe       = oe_q;
    assign ram_we       = we_q;
    assign ram_data     = drv_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_port_driver.sv
// -----------------------------------------------------------------------------
// tb_sram_port_driver
//
// Self-checking bench for sram_port_driver with WAIT_CYCLES=1 and a
// behavioural asynchronous SRAM on a pulled-up data bus (an undriven bus
// reads as all ones). Expected values come from the access rules:
//   read latency  = WAIT+3 cycles after the accept edge
//   write latency = WAIT+3, or 2*WAIT+5 with SRAM_WRITE_READBACK_EN
//   strobe length = WAIT+1, back-to-back spacing = WAIT+4
// and from a reference memory kept as an associative array.
// -----------------------------------------------------------------------------
module tb_sram_port_driver;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int WAIT   = 1;
`ifdef SRAM_WRITE_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int          RD_LAT     = WAIT + 3;
    localparam int          WR_LAT     = RB ? (2 * WAIT + 5) : (WAIT + 3);
    localparam int          STROBE_LEN = WAIT + 1;
    localparam int          B2B_GAP    = WAIT + 4;
    localparam logic [15:0] FLOAT      = 16'hFFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] ram_addr;
    wire  [DATA_W-1:0] ram_data;
    logic              ram_en, ram_oe, ram_we;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_port_driver_if #(.DATA_W(DATA_W)) up ();

    sram_port_driver #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up       (up),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_en   (ram_en),
        .ram_oe   (ram_oe),
        .ram_we   (ram_we)
    );

    // Behavioural SRAM chip
    logic [15:0] sram [0:(1<<ADDR_W)-1];
    bit          corrupt_bit0 = 1'b0;
    wire         chip_drive = !ram_en && !ram_oe;

    pullup pu_bus (ram_data);
    assign ram_data = chip_drive ? sram[ram_addr] : 'z;

    always @(posedge clk) begin
        if (!ram_en && !ram_we)
            sram[ram_addr] = corrupt_bit0 ? (ram_data & 16'hFFFE) : ram_data;
    end

    // Reference memory at word-address level
    logic [15:0] ref_mem [int unsigned];

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
    endfunction

    // Runs one access starting in an IDLE cycle; at cycle 'chg' after accept
    // the request is dropped and addr/data/op scrambled.
    task automatic run_access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                              input int chg, output int lat, output int oe_lo,
                              output int we_lo, output int addr_bad, output int bus_bad,
                              output bit tail_done);
        logic [15:0] exp_bus;
        lat = -1; oe_lo = 0; we_lo = 0; addr_bad = 0; bus_bad = 0;
        up.need_to_work = 1'b1; up.mem_rd = !wr; up.mem_wr = wr;
        up.addr = a; up.data_in = d;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (!ram_oe) oe_lo++;
            if (!ram_we) we_lo++;
            if (!ram_en && ram_addr !== {2'b00, a}) addr_bad++;
            if (ram_oe) begin
                exp_bus = FLOAT;
                if (wr && (n <= WAIT + 2 || (!RB && n == WR_LAT))) exp_bus = d;
                if (ram_data !== exp_bus) bus_bad++;
            end
            if (n == chg) begin
                up.need_to_work = 1'b0; up.addr = ~a; up.data_in = ~d;
                up.mem_rd = wr; up.mem_wr = !wr;
            end
            if (up.work_done) begin
                lat = n;
                break;
            end
        end
        up.need_to_work = 1'b0;
        @(negedge clk);
        tail_done = up.work_done;
    endtask

    task automatic test_reset();
        int wd_seen = 0;
        rst = 1'b1;
        up.need_to_work = 1'b0; up.mem_rd = 1'b0; up.mem_wr = 1'b0;
        up.addr = '0; up.data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (up.work_done) wd_seen++;
        end
        n_checks++; if (wd_seen !== 0) begin n_fail++; $display("FAIL reset_work_done: got %0d pulses want 0", wd_seen); end
        n_checks++; if ({ram_en, ram_oe, ram_we} !== 3'b111) begin n_fail++; $display("FAIL reset_strobes: got en/oe/we=%b want 111", {ram_en, ram_oe, ram_we}); end
        n_checks++; if (ram_data !== FLOAT) begin n_fail++; $display("FAIL reset_bus_float: got %h want %h", ram_data, FLOAT); end
        n_checks++; if (up.feedback !== 16'h0000) begin n_fail++; $display("FAIL reset_feedback: got %h want 0000", up.feedback); end
        n_checks++; if (ram_addr !== 18'h00000) begin n_fail++; $display("FAIL reset_addr: got %h want 00000", ram_addr); end
    endtask

    task automatic test_read();
        int lat, oe_lo, we_lo, ab, bb; bit td;
        sram[18'h00123] = 16'hBEEF; ref_mem[32'h0123] = 16'hBEEF;
        run_access(1'b0, 16'h0123, 16'h0000, 1, lat, oe_lo, we_lo, ab, bb, td);
        n_checks++; if (lat !== RD_LAT) begin n_fail++; $display("FAIL read_latency: got %0d want %0d", lat, RD_LAT); end
        n_checks++; if (oe_lo !== STROBE_LEN) begin n_fail++; $display("FAIL read_oe_cycles: got %0d want %0d", oe_lo, STROBE_LEN); end
        n_checks++; if (we_lo !== 0) begin n_fail++; $display("FAIL read_we_cycles: got %0d want 0", we_lo); end
        n_checks++; if (ab !== 0) begin n_fail++; $display("FAIL read_addr: %0d cycles with wrong ram_addr, want 0", ab); end
        n_checks++; if (ram_addr !== 18'h00123) begin n_fail++; $display("FAIL read_addr_latched: got %h want 00123", ram_addr); end
        n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL read_bus: %0d cycles driven unexpectedly, want 0", bb); end
        n_checks++; if (up.feedback !== 16'hBEEF) begin n_fail++; $display("FAIL read_feedback: got %h want BEEF", up.feedback); end
        n_checks++; if (td !== 1'b0) begin n_fail++; $display("FAIL read_idle_after: work_done=%b want 0", td); end
    endtask

    task automatic test_write();
        int lat, oe_lo, we_lo, ab, bb; bit td;
        run_access(1'b1, 16'h8042, 16'h1234, 1, lat, oe_lo, we_lo, ab, bb, td);
        ref_mem[32'h8042] = 16'h1234;
        n_checks++; if (lat !== WR_LAT) begin n_fail++; $display("FAIL write_latency: got %0d want %0d", lat, WR_LAT); end
        n_checks++; if (we_lo !== STROBE_LEN) begin n_fail++; $display("FAIL write_we_cycles: got %0d want %0d", we_lo, STROBE_LEN); end
        n_checks++; if (oe_lo !== (RB ? STROBE_LEN : 0)) begin n_fail++; $display("FAIL write_oe_cycles: got %0d want %0d", oe_lo, RB ? STROBE_LEN : 0); end
        n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL write_bus: %0d cycles with wrong bus value, want 0", bb); end
        n_checks++; if (ab !== 0) begin n_fail++; $display("FAIL write_addr: %0d cycles with wrong ram_addr, want 0", ab); end
        n_checks++; if (sram[18'h08042] !== 16'h1234) begin n_fail++; $display("FAIL write_memory: got %h want 1234", sram[18'h08042]); end
        n_checks++; if (up.feedback !== 16'h1234) begin n_fail++; $display("FAIL write_feedback: got %h want 1234", up.feedback); end
        n_checks++; if (td !== 1'b0) begin n_fail++; $display("FAIL write_idle_after: work_done=%b want 0", td); end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1, low_between = 0;
        bit prev = 1'b0;
        sram[18'h00200] = 16'h0F0F; ref_mem[32'h0200] = 16'h0F0F;
        up.need_to_work = 1'b1; up.mem_rd = 1'b1; up.mem_wr = 1'b0; up.addr = 16'h0200;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (up.work_done && !prev) begin
                if (first < 0) first = n;
                else begin
                    second = n;
                    up.need_to_work = 1'b0;
                    break;
                end
            end else if (first >= 0 && !up.work_done) begin
                low_between++;
            end
            prev = up.work_done;
        end
        up.need_to_work = 1'b0;
        n_checks++; if (second - first !== B2B_GAP) begin n_fail++; $display("FAIL b2b_spacing: got %0d (pulses at %0d,%0d) want %0d", second - first, first, second, B2B_GAP); end
        n_checks++; if (low_between !== B2B_GAP - 1) begin n_fail++; $display("FAIL b2b_low_between: got %0d low cycles want %0d", low_between, B2B_GAP - 1); end
        n_checks++; if (up.feedback !== 16'h0F0F) begin n_fail++; $display("FAIL b2b_feedback: got %h want 0F0F", up.feedback); end
        // Request was dropped in the second DONE cycle: no third access may start.
        low_between = 0;
        repeat (6) begin
            @(negedge clk);
            if (!ram_en || up.work_done) low_between++;
        end
        n_checks++; if (low_between !== 0) begin n_fail++; $display("FAIL b2b_no_third: got %0d active cycles want 0", low_between); end
    endtask

    task automatic test_mid_access_change();
        int lat, oe_lo, we_lo, ab, bb; bit td;
        int active = 0;
        sram[18'h00321] = 16'h7E57; ref_mem[32'h0321] = 16'h7E57;
        run_access(1'b0, 16'h0321, 16'h0000, 2, lat, oe_lo, we_lo, ab, bb, td);
        n_checks++; if (lat !== RD_LAT) begin n_fail++; $display("FAIL mid_latency: got %0d want %0d", lat, RD_LAT); end
        n_checks++; if (ab !== 0) begin n_fail++; $display("FAIL mid_addr_stable: %0d cycles with wrong ram_addr, want 0", ab); end
        n_checks++; if (we_lo !== 0) begin n_fail++; $display("FAIL mid_op_latched: got %0d we cycles want 0", we_lo); end
        n_checks++; if (up.feedback !== 16'h7E57) begin n_fail++; $display("FAIL mid_feedback: got %h want 7E57", up.feedback); end
        repeat (4) begin
            @(negedge clk);
            if (!ram_en) active++;
        end
        n_checks++; if (active !== 0) begin n_fail++; $display("FAIL mid_no_new_access: got %0d enabled cycles want 0", active); end
    endtask

    task automatic test_ignore_no_op();
        int active = 0;
        up.need_to_work = 1'b1; up.mem_rd = 1'b0; up.mem_wr = 1'b0; up.addr = 16'h0055;
        repeat (5) begin
            @(negedge clk);
            if (!ram_en || up.work_done) active++;
        end
        up.need_to_work = 1'b0;
        n_checks++; if (active !== 0) begin n_fail++; $display("FAIL ignore_no_op: got %0d active cycles want 0", active); end
    endtask

    task automatic test_reset_abort();
        int we_lo = 0, wd = 0;
        up.need_to_work = 1'b1; up.mem_rd = 1'b0; up.mem_wr = 1'b1;
        up.addr = 16'h0050; up.data_in = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);               // SETUP
        up.need_to_work = 1'b0;
        @(negedge clk);               // first STROBE cycle
        if (!ram_we) we_lo++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({ram_en, ram_oe, ram_we} !== 3'b111) begin n_fail++; $display("FAIL abort_strobes: got en/oe/we=%b want 111", {ram_en, ram_oe, ram_we}); end
        n_checks++; if (ram_data !== FLOAT) begin n_fail++; $display("FAIL abort_bus: got %h want %h", ram_data, FLOAT); end
        n_checks++; if (up.feedback !== 16'h0000) begin n_fail++; $display("FAIL abort_feedback: got %h want 0000", up.feedback); end
        if (up.work_done) wd++;
        repeat (6) begin
            @(negedge clk);
            if (!ram_we) we_lo++;
            if (up.work_done) wd++;
        end
        n_checks++; if (we_lo !== 1) begin n_fail++; $display("FAIL abort_we_cycles: got %0d want 1", we_lo); end
        n_checks++; if (wd !== 0) begin n_fail++; $display("FAIL abort_work_done: got %0d pulses want 0", wd); end
    endtask

    task automatic test_random();
        int lat, oe_lo, we_lo, ab, bb; bit td;
        logic [15:0] a, d, exp_fb;
        int idx; bit wr;
        for (int i = 0; i < 64; i++) begin
            a = (i < 32) ? 16'(i) : 16'(32'h8000 + i - 32);
            d = 16'($urandom_range(0, 16'hFFFE));
            sram[{2'b00, a}] = d; ref_mem[int'(a)] = d;
        end
        for (int t = 0; t < 40; t++) begin
            wr  = 1'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 63));
            a   = (idx < 32) ? 16'(idx) : 16'(32'h8000 + idx - 32);
            d   = 16'($urandom_range(0, 16'hFFFE));
            exp_fb = wr ? d : ref_read(a);
            run_access(wr, a, d, 1, lat, oe_lo, we_lo, ab, bb, td);
            if (wr) ref_mem[int'(a)] = d;
            n_checks++; if (lat !== (wr ? WR_LAT : RD_LAT)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", t, lat, wr ? WR_LAT : RD_LAT); end
            n_checks++; if (we_lo !== (wr ? STROBE_LEN : 0)) begin n_fail++; $display("FAIL rand_we[%0d]: got %0d want %0d", t, we_lo, wr ? STROBE_LEN : 0); end
            n_checks++; if (oe_lo !== ((!wr || RB) ? STROBE_LEN : 0)) begin n_fail++; $display("FAIL rand_oe[%0d]: got %0d want %0d", t, oe_lo, (!wr || RB) ? STROBE_LEN : 0); end
            n_checks++; if (ab !== 0 || bb !== 0) begin n_fail++; $display("FAIL rand_pins[%0d]: addr errors %0d bus errors %0d want 0/0", t, ab, bb); end
            n_checks++; if (up.feedback !== exp_fb) begin n_fail++; $display("FAIL rand_feedback[%0d]: got %h want %h (addr %h wr %0d)", t, up.feedback, exp_fb, a, wr); end
            n_checks++; if (sram[{2'b00, a}] !== ref_read(a)) begin n_fail++; $display("FAIL rand_memory[%0d]: got %h want %h", t, sram[{2'b00, a}], ref_read(a)); end
            n_checks++; if (td !== 1'b0) begin n_fail++; $display("FAIL rand_idle_after[%0d]: work_done=%b want 0", t, td); end
        end
    endtask

`ifdef SRAM_WRITE_READBACK_EN
    task automatic test_readback();
        int lat, oe_lo, we_lo, ab, bb; bit td;
        run_access(1'b1, 16'h0007, 16'hA5A5, 1, lat, oe_lo, we_lo, ab, bb, td);
        n_checks++; if (lat !== 2 * WAIT + 5) begin n_fail++; $display("FAIL rb_latency: got %0d want %0d", lat, 2 * WAIT + 5); end
        n_checks++; if (up.feedback !== 16'hA5A5) begin n_fail++; $display("FAIL rb_feedback: got %h want A5A5", up.feedback); end
        corrupt_bit0 = 1'b1;
        run_access(1'b1, 16'h0007, 16'hA5A5, 1, lat, oe_lo, we_lo, ab, bb, td);
        corrupt_bit0 = 1'b0;
        ref_mem[32'h0007] = 16'hA5A4;
        n_checks++; if (up.feedback !== 16'hA5A4) begin n_fail++; $display("FAIL rb_corrupt_feedback: got %h want A5A4", up.feedback); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_mid_access_change();
        test_ignore_no_op();
        test_reset_abort();
`ifdef SRAM_WRITE_READBACK_EN
        test_readback();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
